// File: rtl/absmem_check_seq.sv
// absmem_check_seq: upstream sequencer for the dual-side abstract memory.
// It issues one arm pulse, waits for both sides to commit (freezing each one
// as it commits), pulses compare, and latches a sticky pass/fail/timeout verdict
// together with the commit latency in RUN cycles.
module absmem_check_seq #(
  parameter int MAX_CYC = 64,
  parameter int CNT_W   = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             vlg_done,
  input  logic             ila_done,
  input  logic             mem_equal,
  input  logic             state_eq,
  output logic             issue,
  output logic             compare,
  output logic             vlg_hold,
  output logic             ila_hold,
  output logic             busy,
  output logic             result_valid,
  output logic             pass,
  output logic             timeout,
  output logic [CNT_W-1:0] cycles
);

  localparam logic [CNT_W-1:0] LP_MAX = CNT_W'(MAX_CYC);
  localparam logic [CNT_W-1:0] LP_LIM = CNT_W'(MAX_CYC - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_RUN,
    S_COMPARE,
    S_DONE
  } state_t;

  state_t           r_state;
  state_t           w_state_n;
  logic [CNT_W-1:0] r_cnt;
  logic             r_vlg_seen;
  logic             r_ila_seen;
  logic             r_issue;
  logic             r_compare;
  logic             r_busy;
  logic             r_result_valid;
  logic             r_pass;
  logic             r_timeout;
  logic [CNT_W-1:0] r_cycles;

  logic             w_vlg_seen_n;
  logic             w_ila_seen_n;
  logic             w_both;
  logic             w_at_limit;

  // A side counts as committed once its pulse arrives; repeats are harmless.
  assign w_vlg_seen_n = r_vlg_seen | vlg_done;
  assign w_ila_seen_n = r_ila_seen | ila_done;
  assign w_both       = w_vlg_seen_n & w_ila_seen_n;
  assign w_at_limit   = (r_cnt == LP_LIM);

  // Next-state logic; completing the pair beats the timeout limit.
  always_comb begin
    // NOTE: default first so every path assigns w_state_n and no latch is inferred.
    w_state_n = r_state;
    case (r_state)
      S_IDLE:    if (start) w_state_n = S_ISSUE;
      S_ISSUE:   w_state_n = S_RUN;
      S_RUN: begin
        if (w_both)          w_state_n = S_COMPARE;
        else if (w_at_limit) w_state_n = S_DONE;
      end
      S_COMPARE: w_state_n = S_DONE;
      S_DONE:    w_state_n = S_DONE;
      default:   w_state_n = S_IDLE;
    endcase
  end

  // State register; only rst leaves DONE.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments keep all registers updating from the same pre-edge values.
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_n;
  end

  // Registered outputs, commit flags, counter and verdict.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt          <= '0;
      r_vlg_seen     <= 1'b0;
      r_ila_seen     <= 1'b0;
      r_issue        <= 1'b0;
      r_compare      <= 1'b0;
      r_busy         <= 1'b0;
      r_result_valid <= 1'b0;
      r_pass         <= 1'b0;
      r_timeout      <= 1'b0;
      r_cycles       <= '0;
    end else begin
      r_issue   <= (r_state == S_IDLE) && start;
      r_compare <= (r_state == S_RUN) && w_both;
      r_busy    <= (w_state_n == S_ISSUE) || (w_state_n == S_RUN) ||
                   (w_state_n == S_COMPARE);
      case (r_state)
        S_ISSUE: r_cnt <= '0;
        S_RUN: begin
          r_vlg_seen <= w_vlg_seen_n;
          r_ila_seen <= w_ila_seen_n;
          if (r_cnt != LP_MAX) r_cnt <= r_cnt + 1'b1;
          if (w_both) begin
            r_cycles <= r_cnt + 1'b1;
          end else if (w_at_limit) begin
            r_timeout      <= 1'b1;
            r_pass         <= 1'b0;
            r_cycles       <= LP_MAX;
            r_result_valid <= 1'b1;
          end
        end
        S_COMPARE: begin
          r_pass         <= mem_equal & state_eq;
          r_timeout      <= 1'b0;
          r_result_valid <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign issue        = r_issue;
  assign compare      = r_compare;
  assign vlg_hold     = r_vlg_seen;
  assign ila_hold     = r_ila_seen;
  assign busy         = r_busy;
  assign result_valid = r_result_valid;
  assign pass         = r_pass;
  assign timeout      = r_timeout;
  assign cycles       = r_cycles;

endmodule

// File: tb/tb_absmem_check_seq.sv
// Directed bench for absmem_check_seq with MAX_CYC=8.
module tb_absmem_check_seq;

  localparam int MAX_CYC = 8;
  localparam int CNT_W   = 4;

  logic             clk = 1'b0;
  logic             rst, start, vlg_done, ila_done, mem_equal, state_eq;
  logic             issue, compare, vlg_hold, ila_hold, busy;
  logic             result_valid, pass, timeout;
  logic [CNT_W-1:0] cycles;

  int total = 0;
  int bad   = 0;
  logic cmp_seen;

  absmem_check_seq #(.MAX_CYC(MAX_CYC), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .start(start), .vlg_done(vlg_done),
    .ila_done(ila_done), .mem_equal(mem_equal), .state_eq(state_eq),
    .issue(issue), .compare(compare), .vlg_hold(vlg_hold),
    .ila_hold(ila_hold), .busy(busy), .result_valid(result_valid),
    .pass(pass), .timeout(timeout), .cycles(cycles)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one edge and settle past it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; start = 1'b0; vlg_done = 1'b0; ila_done = 1'b0;
    mem_equal = 1'b0; state_eq = 1'b0;
    step();
    rst = 1'b0;
  endtask

  function automatic logic [12:0] all_outs();
    return {issue, compare, vlg_hold, ila_hold, busy, result_valid, pass, timeout, cycles};
  endfunction

  // Start, vlg_done in RUN cycle 3, ila_done in RUN cycle 5, then COMPARE.
  task automatic normal_seq(input logic m, input logic e);
    start = 1'b1; step(); start = 1'b0;
    check("n_issue", issue, 1);
    check("n_busy", busy, 1);
    step();                       // RUN 1
    check("n_issue_drop", issue, 0);
    step(); step();               // RUN 3
    check("n_vhold_pre", vlg_hold, 0);
    vlg_done = 1'b1; step(); vlg_done = 1'b0;  // RUN 4
    check("n_vhold", vlg_hold, 1);
    check("n_ihold_pre", ila_hold, 0);
    step();                       // RUN 5
    ila_done = 1'b1; step(); ila_done = 1'b0;  // COMPARE
    check("n_compare", compare, 1);
    check("n_no_issue", issue, 0);
    check("n_rv_pre", result_valid, 0);
    mem_equal = m; state_eq = e; step(); mem_equal = 1'b0; state_eq = 1'b0;
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; vlg_done = 1'b0; ila_done = 1'b0;
    mem_equal = 1'b0; state_eq = 1'b0;
    step(); step();
    check("reset_outs", all_outs(), 0);
    rst = 1'b0;

    // Normal pass.
    normal_seq(1'b1, 1'b1);
    check("p_rv", result_valid, 1);
    check("p_pass", pass, 1);
    check("p_timeout", timeout, 0);
    check("p_cycles", cycles, 5);
    check("p_busy", busy, 0);
    check("p_compare_drop", compare, 0);
    check("p_holds", {vlg_hold, ila_hold}, 2'b11);
    start = 1'b1; step(); start = 1'b0;
    check("p_done_start_issue", issue, 0);
    step();
    check("p_sticky", {result_valid, pass, cycles}, {1'b1, 1'b1, 4'd5});

    // Memory mismatch.
    do_reset();
    normal_seq(1'b0, 1'b1);
    check("m_rv", result_valid, 1);
    check("m_pass", pass, 0);
    check("m_timeout", timeout, 0);
    check("m_cycles", cycles, 5);

    // Timeout: only vlg_done arrives.
    do_reset();
    start = 1'b1; step(); start = 1'b0;
    step();                       // RUN 1
    vlg_done = 1'b1; step(); vlg_done = 1'b0;  // RUN 2
    cmp_seen = 1'b0;
    for (int i = 0; i < 6; i++) begin
      cmp_seen = cmp_seen | compare;
      step();
    end                           // RUN 8
    check("t_busy_at_8", busy, 1);
    check("t_rv_at_8", result_valid, 0);
    cmp_seen = cmp_seen | compare;
    step();                       // DONE
    cmp_seen = cmp_seen | compare;
    check("t_timeout", timeout, 1);
    check("t_cycles", cycles, 8);
    check("t_pass", pass, 0);
    check("t_rv", result_valid, 1);
    check("t_busy", busy, 0);
    check("t_no_compare", cmp_seen, 0);
    check("t_holds", {vlg_hold, ila_hold}, 2'b10);

    // Boundary: pair completes in RUN cycle 8.
    do_reset();
    start = 1'b1; step(); start = 1'b0;
    step(); step();               // RUN 2
    ila_done = 1'b1; step(); ila_done = 1'b0;  // RUN 3
    repeat (5) step();            // RUN 8
    check("b_busy_at_8", busy, 1);
    vlg_done = 1'b1; step(); vlg_done = 1'b0;
    check("b_compare", compare, 1);
    check("b_timeout_mid", timeout, 0);
    mem_equal = 1'b1; state_eq = 1'b1; step(); mem_equal = 1'b0; state_eq = 1'b0;
    check("b_cycles", cycles, 8);
    check("b_timeout", timeout, 0);
    check("b_pass", pass, 1);

    // Ignored events and simultaneous commits.
    do_reset();
    vlg_done = 1'b1; ila_done = 1'b1; step();  // IDLE
    check("i_idle_outs", all_outs(), 0);
    start = 1'b1; step();         // ISSUE, dones still high
    check("i_issue", issue, 1);
    step();                       // RUN 1, start held high while busy
    check("i_issue_once", issue, 0);
    check("i_holds_after_issue", {vlg_hold, ila_hold}, 2'b00);
    step();                       // both dones in RUN 1 -> COMPARE
    vlg_done = 1'b0; ila_done = 1'b0; start = 1'b0;
    check("i_compare", compare, 1);
    check("i_no_issue", issue, 0);
    mem_equal = 1'b1; state_eq = 1'b1; step(); mem_equal = 1'b0; state_eq = 1'b0;
    check("i_cycles", cycles, 1);
    check("i_pass", pass, 1);

    // Reset mid-RUN, then a fresh complete check.
    do_reset();
    start = 1'b1; step(); start = 1'b0;
    step();                       // RUN 1
    vlg_done = 1'b1; step(); vlg_done = 1'b0;
    check("r_vhold", vlg_hold, 1);
    rst = 1'b1; step(); rst = 1'b0;
    check("r_outs", all_outs(), 0);
    start = 1'b1; step(); start = 1'b0;
    check("r_issue", issue, 1);
    step();                       // RUN 1
    ila_done = 1'b1; step(); ila_done = 1'b0;  // RUN 2
    check("r_holds_fresh", {vlg_hold, ila_hold}, 2'b01);
    vlg_done = 1'b1; step(); vlg_done = 1'b0;
    check("r_compare", compare, 1);
    mem_equal = 1'b1; state_eq = 1'b1; step(); mem_equal = 1'b0; state_eq = 1'b0;
    check("r_verdict", {result_valid, pass, timeout, cycles}, {1'b1, 1'b1, 1'b0, 4'd2});

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
